// File: rtl/itch_msg_decoder_pkg.sv
// Shared constants and types for the ITCH 5.0 message decoder.
// Type codes, per-type minimum lengths, field offsets and FSM encodings.
package itch_msg_decoder_pkg;

  localparam logic [7:0] ITCH_ADD      = 8'h41;
  localparam logic [7:0] ITCH_ADD_MPID = 8'h46;
  localparam logic [7:0] ITCH_DEL      = 8'h44;
  localparam logic [7:0] ITCH_EXEC     = 8'h45;
  localparam logic [7:0] ITCH_BUY      = 8'h42;

  localparam logic [15:0] LEN_ADD      = 16'd36;
  localparam logic [15:0] LEN_ADD_MPID = 16'd40;
  localparam logic [15:0] LEN_DEL      = 16'd19;
  localparam logic [15:0] LEN_EXEC     = 16'd31;

  // Offsets count from the type byte (offset 0).
  localparam logic [15:0] OFF_LOCATE      = 16'd1;
  localparam logic [15:0] OFF_REF         = 16'd11;
  localparam logic [15:0] OFF_BUY_SELL    = 16'd19;
  localparam logic [15:0] OFF_ADD_SHARES  = 16'd20;
  localparam logic [15:0] OFF_ADD_PRICE   = 16'd32;
  localparam logic [15:0] OFF_EXEC_SHARES = 16'd19;

  localparam int unsigned REF_BYTES    = 8;
  localparam int unsigned SHARES_BYTES = 4;
  localparam int unsigned PRICE_BYTES  = 4;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StType,
    StBody,
    StSkip
  } decState_t;

  typedef enum logic [1:0] {
    KindNone,
    KindAdd,
    KindDel,
    KindExec
  } msgKind_t;

  function automatic logic [15:0] minLenOf(input logic [7:0] typeCode);
    case (typeCode)
      ITCH_ADD:      minLenOf = LEN_ADD;
      ITCH_ADD_MPID: minLenOf = LEN_ADD_MPID;
      ITCH_DEL:      minLenOf = LEN_DEL;
      ITCH_EXEC:     minLenOf = LEN_EXEC;
      default:       minLenOf = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_field_shifter.sv
// Offset-addressed big-endian capture of a multi-byte field into a shadow register.
// Bytes inside the window shift in from the LSB, so the field ends right-aligned.
module itch_field_shifter #(
  parameter int unsigned Width    = 64,
  parameter int unsigned NumBytes = 8
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             clearIn,
  input  logic             enIn,
  input  logic [15:0]      offsetIn,
  input  logic [15:0]      startIn,
  input  logic [7:0]       dataIn,
  output logic [Width-1:0] shadowNextOut,
  output logic [Width-1:0] shadowOut
);

  logic inWindow;

  always_comb begin
    inWindow = enIn && (offsetIn >= startIn) && (offsetIn < (startIn + 16'(NumBytes)));
    shadowNextOut = shadowOut;
    if (clearIn) begin
      shadowNextOut = '0;
    end else if (inWindow) begin
      shadowNextOut = {shadowOut[Width-9:0], dataIn};
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      shadowOut <= '0;
    end else begin
      shadowOut <= shadowNextOut;
    end
  end

endmodule

// File: rtl/itch_msg_decoder.sv
// Byte-serial ITCH 5.0 decoder: length-prefixed messages in, registered
// Add/Delete/Executed pulses with order fields out, plus saturating statistics.
module itch_msg_decoder
  import itch_msg_decoder_pkg::*;
#(
  parameter bit          ACCEPT_MPID = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [7:0]           dataIn,
  input  logic                 dataValidIn,
  input  logic                 dataLastIn,
  output logic                 addValidOut,
  output logic                 delValidOut,
  output logic                 execValidOut,
  output logic [63:0]          refNumOut,
  output logic [15:0]          locateOut,
  output logic [31:0]          priceOut,
  output logic [31:0]          sharesOut,
  output logic                 buySellOut,
  output logic [CNT_WIDTH-1:0] msgCountOut,
  output logic [CNT_WIDTH-1:0] errCountOut
);

  decState_t   stateQ, stateD;
  msgKind_t    kindQ, kindD;
  logic [15:0] lenQ, lenD;
  logic [15:0] remQ, remD;
  logic [15:0] offQ, offD;
  logic        shortQ, shortD;
  logic [15:0] locateQ, locateD;
  logic        buySellQ, buySellD;

  logic addFire, delFire, execFire, errFire;
  logic lastByte;
  logic isKnown;
  logic [15:0] lenLoVal;

  logic        shadowClear;
  logic        bodyEn;
  logic [15:0] sharesStart;
  logic [63:0] refNext, refShadow;
  logic [31:0] priceNext, priceShadow;
  logic [31:0] sharesNext, sharesShadow;

  assign shadowClear = dataValidIn && (stateQ == StType);
  assign bodyEn      = dataValidIn && (stateQ == StBody);
  assign sharesStart = (kindQ == KindExec) ? OFF_EXEC_SHARES : OFF_ADD_SHARES;

  itch_field_shifter #(
    .Width   (64),
    .NumBytes(REF_BYTES)
  ) u_refShifter (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .clearIn      (shadowClear),
    .enIn         (bodyEn),
    .offsetIn     (offQ),
    .startIn      (OFF_REF),
    .dataIn       (dataIn),
    .shadowNextOut(refNext),
    .shadowOut    (refShadow)
  );

  itch_field_shifter #(
    .Width   (32),
    .NumBytes(PRICE_BYTES)
  ) u_priceShifter (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .clearIn      (shadowClear),
    .enIn         (bodyEn && (kindQ == KindAdd)),
    .offsetIn     (offQ),
    .startIn      (OFF_ADD_PRICE),
    .dataIn       (dataIn),
    .shadowNextOut(priceNext),
    .shadowOut    (priceShadow)
  );

  itch_field_shifter #(
    .Width   (32),
    .NumBytes(SHARES_BYTES)
  ) u_sharesShifter (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .clearIn      (shadowClear),
    .enIn         (bodyEn && ((kindQ == KindAdd) || (kindQ == KindExec))),
    .offsetIn     (offQ),
    .startIn      (sharesStart),
    .dataIn       (dataIn),
    .shadowNextOut(sharesNext),
    .shadowOut    (sharesShadow)
  );

  always_comb begin
    stateD   = stateQ;
    kindD    = kindQ;
    lenD     = lenQ;
    remD     = remQ;
    offD     = offQ;
    shortD   = shortQ;
    locateD  = locateQ;
    buySellD = buySellQ;
    addFire  = 1'b0;
    delFire  = 1'b0;
    execFire = 1'b0;
    errFire  = 1'b0;
    lastByte = (remQ == 16'd1);
    lenLoVal = {lenQ[15:8], dataIn};
    isKnown  = (dataIn == ITCH_ADD) || (dataIn == ITCH_DEL) || (dataIn == ITCH_EXEC) ||
               ((dataIn == ITCH_ADD_MPID) && ACCEPT_MPID);

    if (dataValidIn) begin
      unique case (stateQ)
        StLenHi: begin
          lenD = {dataIn, 8'h00};
          // A packet ending on a lone length byte just resynchronises.
          stateD = dataLastIn ? StLenHi : StLenLo;
        end
        StLenLo: begin
          lenD = lenLoVal;
          remD = lenLoVal;
          if (dataLastIn) begin
            errFire = 1'b1;
            stateD  = StLenHi;
          end else if (lenLoVal == 16'd0) begin
            stateD = StLenHi;
          end else begin
            stateD = StType;
          end
        end
        StType: begin
          remD     = remQ - 16'd1;
          offD     = 16'd1;
          locateD  = '0;
          buySellD = 1'b0;
          shortD   = lenQ < minLenOf(dataIn);
          if (!isKnown) begin
            kindD = KindNone;
          end else if (dataIn == ITCH_DEL) begin
            kindD = KindDel;
          end else if (dataIn == ITCH_EXEC) begin
            kindD = KindExec;
          end else begin
            kindD = KindAdd;
          end
          if (lastByte) begin
            // A one-byte message of a decodable type is always short.
            errFire = isKnown;
            stateD  = StLenHi;
          end else if (dataLastIn) begin
            errFire = 1'b1;
            stateD  = StLenHi;
          end else begin
            stateD = isKnown ? StBody : StSkip;
          end
        end
        StBody: begin
          remD = remQ - 16'd1;
          offD = offQ + 16'd1;
          if (offQ == OFF_LOCATE) begin
            locateD[15:8] = dataIn;
          end
          if (offQ == OFF_LOCATE + 16'd1) begin
            locateD[7:0] = dataIn;
          end
          if ((offQ == OFF_BUY_SELL) && (kindQ == KindAdd)) begin
            buySellD = (dataIn == ITCH_BUY);
          end
          if (lastByte) begin
            stateD = StLenHi;
            if (shortQ) begin
              errFire = 1'b1;
            end else begin
              addFire  = (kindQ == KindAdd);
              delFire  = (kindQ == KindDel);
              execFire = (kindQ == KindExec);
            end
          end else if (dataLastIn) begin
            errFire = 1'b1;
            stateD  = StLenHi;
          end
        end
        StSkip: begin
          remD = remQ - 16'd1;
          if (lastByte) begin
            stateD = StLenHi;
          end else if (dataLastIn) begin
            errFire = 1'b1;
            stateD  = StLenHi;
          end
        end
        default: stateD = StLenHi;
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      stateQ   <= StLenHi;
      kindQ    <= KindNone;
      lenQ     <= '0;
      remQ     <= '0;
      offQ     <= '0;
      shortQ   <= 1'b0;
      locateQ  <= '0;
      buySellQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      kindQ    <= kindD;
      lenQ     <= lenD;
      remQ     <= remD;
      offQ     <= offD;
      shortQ   <= shortD;
      locateQ  <= locateD;
      buySellQ <= buySellD;
    end
  end

  // Output fields load from the next-state shadows so the final byte is included.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      addValidOut  <= 1'b0;
      delValidOut  <= 1'b0;
      execValidOut <= 1'b0;
      refNumOut    <= '0;
      locateOut    <= '0;
      priceOut     <= '0;
      sharesOut    <= '0;
      buySellOut   <= 1'b0;
      msgCountOut  <= '0;
      errCountOut  <= '0;
    end else begin
      addValidOut  <= addFire;
      delValidOut  <= delFire;
      execValidOut <= execFire;
      if (addFire || delFire || execFire) begin
        refNumOut   <= refNext;
        locateOut   <= locateD;
        priceOut    <= addFire ? priceNext : '0;
        sharesOut   <= delFire ? '0 : sharesNext;
        buySellOut  <= addFire && buySellD;
        if (msgCountOut != '1) begin
          msgCountOut <= msgCountOut + CNT_WIDTH'(1);
        end
      end
      if (errFire && (errCountOut != '1)) begin
        errCountOut <= errCountOut + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_itch_msg_decoder.sv
// Directed self-checking bench for itch_msg_decoder, with a second instance
// built with ACCEPT_MPID=0 fed the same byte stream.
module tb_itch_msg_decoder;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic        dataValidIn = 1'b0;
  logic        dataLastIn = 1'b0;

  logic        addValidOut, delValidOut, execValidOut, buySellOut;
  logic [63:0] refNumOut;
  logic [15:0] locateOut, msgCountOut, errCountOut;
  logic [31:0] priceOut, sharesOut;

  logic        nAddValid, nDelValid, nExecValid, nBuySell;
  logic [63:0] nRefNum;
  logic [15:0] nLocate, nMsgCount, nErrCount;
  logic [31:0] nPrice, nShares;

  int nChecks = 0;
  int nPass = 0;
  int addPulses = 0;
  int delPulses = 0;
  int execPulses = 0;
  int multiPulse = 0;
  int nAddPulses = 0;

  logic [7:0] msg[$];

  always #5 clkIn = ~clkIn;

  itch_msg_decoder #(
    .ACCEPT_MPID(1'b1),
    .CNT_WIDTH  (16)
  ) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .dataIn      (dataIn),
    .dataValidIn (dataValidIn),
    .dataLastIn  (dataLastIn),
    .addValidOut (addValidOut),
    .delValidOut (delValidOut),
    .execValidOut(execValidOut),
    .refNumOut   (refNumOut),
    .locateOut   (locateOut),
    .priceOut    (priceOut),
    .sharesOut   (sharesOut),
    .buySellOut  (buySellOut),
    .msgCountOut (msgCountOut),
    .errCountOut (errCountOut)
  );

  itch_msg_decoder #(
    .ACCEPT_MPID(1'b0),
    .CNT_WIDTH  (16)
  ) dutNoMpid (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .dataIn      (dataIn),
    .dataValidIn (dataValidIn),
    .dataLastIn  (dataLastIn),
    .addValidOut (nAddValid),
    .delValidOut (nDelValid),
    .execValidOut(nExecValid),
    .refNumOut   (nRefNum),
    .locateOut   (nLocate),
    .priceOut    (nPrice),
    .sharesOut   (nShares),
    .buySellOut  (nBuySell),
    .msgCountOut (nMsgCount),
    .errCountOut (nErrCount)
  );

  always @(negedge clkIn) begin
    if (addValidOut) addPulses++;
    if (delValidOut) delPulses++;
    if (execValidOut) execPulses++;
    if (nAddValid) nAddPulses++;
    if ((32'(addValidOut) + 32'(delValidOut) + 32'(execValidOut)) > 1) multiPulse++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      nPass++;
    end
  endtask

  task automatic putN(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) msg.push_back(v[8*i +: 8]);
  endtask

  task automatic fitLen(input int len);
    while (msg.size() < len + 2) msg.push_back(8'hEE);
    while (msg.size() > len + 2) void'(msg.pop_back());
  endtask

  task automatic mkAdd(input int len, input logic [7:0] typ, input logic [15:0] loc,
                       input logic [63:0] refN, input logic [7:0] bs,
                       input logic [31:0] shares, input logic [31:0] price);
    msg.delete();
    putN(64'(len), 2);
    msg.push_back(typ);
    putN(64'(loc), 2);
    putN(64'h0102_0304_0506_0708, 8);
    putN(refN, 8);
    msg.push_back(bs);
    putN(64'(shares), 4);
    putN(64'h4142_4344_4546_4748, 8);
    putN(64'(price), 4);
    fitLen(len);
  endtask

  task automatic mkDel(input int len, input logic [15:0] loc, input logic [63:0] refN);
    msg.delete();
    putN(64'(len), 2);
    msg.push_back(8'h44);
    putN(64'(loc), 2);
    putN(64'h1111_2222_3333_4444, 8);
    putN(refN, 8);
    fitLen(len);
  endtask

  task automatic mkExec(input int len, input logic [15:0] loc, input logic [63:0] refN,
                        input logic [31:0] shares);
    msg.delete();
    putN(64'(len), 2);
    msg.push_back(8'h45);
    putN(64'(loc), 2);
    putN(64'h9999_8888_7777_6666, 8);
    putN(refN, 8);
    putN(64'(shares), 4);
    putN(64'hDEAD_BEEF_CAFE_F00D, 8);
    fitLen(len);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    dataIn = b;
    dataValidIn = 1'b1;
    dataLastIn = last;
    @(posedge clkIn);
    #1;
    dataValidIn = 1'b0;
    dataLastIn = 1'b0;
  endtask

  // truncAt < 0 sends the whole message; otherwise stops with dataLastIn at that index.
  task automatic sendMsg(input logic lastOnFinal, input int truncAt, input logic bubbles);
    for (int i = 0; i < msg.size(); i++) begin
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        @(posedge clkIn);
        #1;
      end
      if (i == truncAt) begin
        sendByte(msg[i], 1'b1);
        break;
      end
      sendByte(msg[i], lastOnFinal && (i == msg.size() - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clkIn);
      #1;
    end
  endtask

  initial begin
    int savedAdds;

    idle(2);
    chk("rstAddValid", 64'(addValidOut), 64'd0);
    chk("rstRef", refNumOut, 64'd0);
    chk("rstMsgCount", 64'(msgCountOut), 64'd0);
    chk("rstErrCount", 64'(errCountOut), 64'd0);
    rstIn = 1'b1;
    idle(2);

    // Plain Add, buy side
    mkAdd(36, 8'h41, 16'h0007, 64'h1234, 8'h42, 32'd100, 32'h0001_86A0);
    sendMsg(1'b1, -1, 1'b0);
    chk("addValid", 64'(addValidOut), 64'd1);
    chk("addRef", refNumOut, 64'h1234);
    chk("addLocate", 64'(locateOut), 64'h7);
    chk("addPrice", 64'(priceOut), 64'h186A0);
    chk("addShares", 64'(sharesOut), 64'd100);
    chk("addBuySell", 64'(buySellOut), 64'd1);
    chk("addMsgCount", 64'(msgCountOut), 64'd1);
    idle(1);
    chk("addPulseDrop", 64'(addValidOut), 64'd0);
    chk("addRefHold", refNumOut, 64'h1234);

    // Delete then Executed with no idle cycles between them
    mkDel(19, 16'h0003, 64'h1234);
    sendMsg(1'b0, -1, 1'b0);
    chk("delValid", 64'(delValidOut), 64'd1);
    chk("delRef", refNumOut, 64'h1234);
    chk("delPrice", 64'(priceOut), 64'd0);
    chk("delShares", 64'(sharesOut), 64'd0);
    mkExec(31, 16'h0003, 64'h55, 32'd40);
    sendMsg(1'b1, -1, 1'b0);
    chk("execValid", 64'(execValidOut), 64'd1);
    chk("execRef", refNumOut, 64'h55);
    chk("execShares", 64'(sharesOut), 64'd40);
    chk("execPrice", 64'(priceOut), 64'd0);
    chk("execMsgCount", 64'(msgCountOut), 64'd3);

    // Unknown type skipped, then an oversize sell-side Add
    msg.delete();
    putN(64'd12, 2);
    msg.push_back(8'h53);
    fitLen(12);
    sendMsg(1'b0, -1, 1'b0);
    chk("skipNoPulse", 64'(addValidOut | delValidOut | execValidOut), 64'd0);
    chk("skipMsgCount", 64'(msgCountOut), 64'd3);
    mkAdd(38, 8'h41, 16'h0009, 64'hABCD_EF01_2345_6789, 8'h53, 32'd500, 32'h1234_5678);
    sendMsg(1'b1, -1, 1'b0);
    chk("bigValid", 64'(addValidOut), 64'd1);
    chk("bigRef", refNumOut, 64'hABCD_EF01_2345_6789);
    chk("bigPrice", 64'(priceOut), 64'h1234_5678);
    chk("bigShares", 64'(sharesOut), 64'd500);
    chk("bigBuySell", 64'(buySellOut), 64'd0);
    chk("bigMsgCount", 64'(msgCountOut), 64'd4);

    // Truncated Add (packet ends at body offset 20), next packet still decodes
    mkAdd(36, 8'h41, 16'h0001, 64'hFFFF, 8'h42, 32'd1, 32'd1);
    sendMsg(1'b0, 22, 1'b0);
    chk("truncNoPulse", 64'(addValidOut), 64'd0);
    chk("truncErr", 64'(errCountOut), 64'd1);
    chk("truncMsgCount", 64'(msgCountOut), 64'd4);
    mkDel(19, 16'h0002, 64'h77);
    sendMsg(1'b1, -1, 1'b0);
    chk("postTruncDel", 64'(delValidOut), 64'd1);
    chk("postTruncRef", refNumOut, 64'h77);
    chk("postTruncLoc", 64'(locateOut), 64'h2);

    // Short Delete
    mkDel(10, 16'h0002, 64'h88);
    sendMsg(1'b1, -1, 1'b0);
    chk("shortNoPulse", 64'(delValidOut), 64'd0);
    chk("shortErr", 64'(errCountOut), 64'd2);
    chk("shortMsgCount", 64'(msgCountOut), 64'd5);

    // Add with MPID: decoded by one instance, skipped by the other
    mkAdd(40, 8'h46, 16'h0011, 64'h99, 8'h42, 32'd7, 32'h500);
    sendMsg(1'b1, -1, 1'b0);
    chk("mpidValid", 64'(addValidOut), 64'd1);
    chk("mpidRef", refNumOut, 64'h99);
    chk("mpidMsgCount", 64'(msgCountOut), 64'd6);
    chk("noMpidValid", 64'(nAddValid), 64'd0);
    chk("noMpidMsgCount", 64'(nMsgCount), 64'd5);
    chk("noMpidErr", 64'(nErrCount), 64'd2);

    // Same Add as the first, with random idle bubbles
    mkAdd(36, 8'h41, 16'h0007, 64'h1234, 8'h42, 32'd100, 32'h0001_86A0);
    sendMsg(1'b1, -1, 1'b1);
    chk("bubValid", 64'(addValidOut), 64'd1);
    chk("bubRef", refNumOut, 64'h1234);
    chk("bubLocate", 64'(locateOut), 64'h7);
    chk("bubPrice", 64'(priceOut), 64'h186A0);
    chk("bubShares", 64'(sharesOut), 64'd100);
    chk("bubBuySell", 64'(buySellOut), 64'd1);

    // Reset in the middle of an Add body
    idle(1);
    mkAdd(36, 8'h41, 16'h0005, 64'h4444, 8'h42, 32'd3, 32'd3);
    msg = msg[0:14];
    sendMsg(1'b0, -1, 1'b0);
    savedAdds = addPulses;
    #3;
    rstIn = 1'b0;
    #1;
    chk("midRstRef", refNumOut, 64'd0);
    chk("midRstLocate", 64'(locateOut), 64'd0);
    chk("midRstMsgCount", 64'(msgCountOut), 64'd0);
    chk("midRstErr", 64'(errCountOut), 64'd0);
    idle(1);
    rstIn = 1'b1;
    idle(3);
    chk("midRstNoPulse", 64'(addPulses), 64'(savedAdds));
    mkExec(31, 16'h0004, 64'h42, 32'd9);
    sendMsg(1'b1, -1, 1'b0);
    chk("postRstExec", 64'(execValidOut), 64'd1);
    chk("postRstRef", refNumOut, 64'h42);
    chk("postRstShares", 64'(sharesOut), 64'd9);
    chk("postRstMsgCount", 64'(msgCountOut), 64'd1);

    idle(2);
    chk("totalAdds", 64'(addPulses), 64'd4);
    chk("totalDels", 64'(delPulses), 64'd2);
    chk("totalExecs", 64'(execPulses), 64'd2);
    chk("noMpidAdds", 64'(nAddPulses), 64'd3);
    chk("onePulsePerCycle", 64'(multiPulse), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
